// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: segment patterns for
// hex digits 0..F (bit0 = a ... bit6 = g, active-high), the per-slot scan
// state, and a width helper for the counters.
package seg7_scan_ctrl_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // GUARD: start of a slot, every anode off so the previous digit's charge
  // decays before the next anode turns on. DRIVE: remainder of the slot.
  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern decoder (active-high segments).
module seg7_hex_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for one hex digit
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One decoder is shared across all digits; each digit gets a slot of
// SLOT_CYCLES clocks whose first GUARD_CYCLES clocks keep all anodes off.
// Digit data is double-buffered: a load lands in a pending buffer and is moved
// to the active buffer only at a frame boundary, so a frame never tears.
// Every output is registered and lags the internal scan state by one clock.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int CNT_W = cnt_width(SLOT_CYCLES);
  localparam int IDX_W = cnt_width(NUM_DIGITS);
  localparam int FRM_W = cnt_width(BLINK_FRAMES);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // Scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             blink_phase_q, blink_phase_d;

  // Pending (written by load) and active (being displayed) buffers
  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  load_ack_q, load_ack_d;
  logic                  frame_done_q, frame_done_d;

  logic        slot_end;
  logic        frame_end;
  scan_state_e slot_state;
  logic [3:0]  cur_nibble;
  logic [6:0]  dec_seg;
  logic        digit_dark;

  assign slot_end   = en & (cnt_q == CNT_LAST);
  assign frame_end  = slot_end & (idx_q == IDX_LAST);
  assign slot_state = (cnt_q < GUARD_END) ? GUARD : DRIVE;

  assign cur_nibble = act_digits_q[{idx_q, 2'b00} +: 4];
  assign digit_dark = act_blank_q[idx_q] | (act_blink_q[idx_q] & blink_phase_q);

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  // Advance slot counter, digit index, frame counter and blink phase while enabled
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    frm_d         = frm_q;
    blink_phase_d = blink_phase_q;
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (frame_end) begin
      if (frm_q == FRM_LAST) begin
        frm_d         = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Promote pending to active at a frame boundary, then accept any new load;
  // ordering lets a load on the boundary edge queue behind the transfer
  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_blank_d  = pend_blank_q;
    pend_dp_d     = pend_dp_q;
    pend_blink_d  = pend_blink_q;
    pend_flag_d   = pend_flag_q;
    act_digits_d  = act_digits_q;
    act_blank_d   = act_blank_q;
    act_dp_d      = act_dp_q;
    act_blink_d   = act_blink_q;
    load_ack_d    = 1'b0;
    if (frame_end && pend_flag_q) begin
      act_digits_d = pend_digits_q;
      act_blank_d  = pend_blank_q;
      act_dp_d     = pend_dp_q;
      act_blink_d  = pend_blink_q;
      pend_flag_d  = 1'b0;
      load_ack_d   = 1'b1;
    end
    if (load) begin
      pend_digits_d = digits_in;
      pend_blank_d  = blank_in;
      pend_dp_d     = dp_in;
      pend_blink_d  = blink_in;
      pend_flag_d   = 1'b1;
    end
  end

  // Pin values for the current scan position; dark in guard, when disabled,
  // or when the selected digit is blanked or in the off half of its blink
  always_comb begin
    an_n_d       = '1;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b0;
    frame_done_d = frame_end;
    if (en && (slot_state == DRIVE) && !digit_dark) begin
      an_n_d[idx_q] = 1'b0;
      seg_d         = dec_seg;
      dp_d          = act_dp_q[idx_q];
    end
  end

  // Scan position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      frm_q         <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frm_q         <= frm_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Display buffers; active blank resets to all-dark until a load is applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits_q <= '0;
      pend_blank_q  <= '0;
      pend_dp_q     <= '0;
      pend_blink_q  <= '0;
      pend_flag_q   <= 1'b0;
      act_digits_q  <= '0;
      act_blank_q   <= '1;
      act_dp_q      <= '0;
      act_blink_q   <= '0;
    end else begin
      pend_digits_q <= pend_digits_d;
      pend_blank_q  <= pend_blank_d;
      pend_dp_q     <= pend_dp_d;
      pend_blink_q  <= pend_blink_d;
      pend_flag_q   <= pend_flag_d;
      act_digits_q  <= act_digits_d;
      act_blank_q   <= act_blank_d;
      act_dp_q      <= act_dp_d;
      act_blink_q   <= act_blink_d;
    end
  end

  // Output registers, so the board pins never see decode glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_q       <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      an_n_q       <= an_n_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with 4 digits, 4-clock slots, 1-clock guard and
// 2-frame blink half-period. Loaded frames go into a scoreboard queue and are
// popped when the DUT acknowledges them; the following frame is then captured
// slot by slot and compared against patterns built from the bench's own table.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int SC = 4;
  localparam int GC = 1;
  localparam int BF = 2;
  localparam int FL = N * SC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  blank_in, dp_in, blink_in;
  logic        load;
  logic        load_ack, frame_done;
  logic [3:0]  an_n;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SLOT_CYCLES  (SC),
    .GUARD_CYCLES (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .blink_in   (blink_in),
    .load       (load),
    .load_ack   (load_ack),
    .frame_done (frame_done),
    .an_n       (an_n),
    .seg        (seg),
    .dp         (dp)
  );

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  blank;
    logic [3:0]  dpm;
    logic [3:0]  blink;
  } frame_t;

  frame_t sb_q[$];
  frame_t exp_fr;
  frame_t dark_fr;

  int checks   = 0;
  int failures = 0;

  logic [3:0] cap_an  [FL];
  logic [6:0] cap_seg [FL];
  logic       cap_dp  [FL];
  logic       cap_fd  [FL];
  logic       cap_ack [FL];

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Expected {an_n, seg, dp} for slot sample j of a frame showing fr at blink phase ph
  function automatic logic [11:0] exp_slot(input frame_t fr, input int j, input logic ph);
    int d;
    logic [3:0] one;
    logic [11:0] r;
    d = j / SC;
    one = 4'b0001;
    r = {4'hF, 7'h00, 1'b0};
    if ((j % SC) >= GC && !(fr.blank[d] | (fr.blink[d] & ph)))
      r = {~(one << d), ref_seg(fr.dig[d*4 +: 4]), fr.dpm[d]};
    return r;
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_load(input frame_t fr);
    digits_in = fr.dig;
    blank_in  = fr.blank;
    dp_in     = fr.dpm;
    blink_in  = fr.blink;
    load      = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Edges until frame_done is seen (-1 if it never comes)
  task automatic wait_fd(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic capture();
    for (int j = 0; j < FL; j++) begin
      @(posedge clk);
      #1;
      cap_an[j]  = an_n;
      cap_seg[j] = seg;
      cap_dp[j]  = dp;
      cap_fd[j]  = frame_done;
      cap_ack[j] = load_ack;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    step(2);
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    digits_in = '0; blank_in = '0; dp_in = '0; blink_in = '0;
    step(2);
    checks++; if (an_n !== 4'hF) begin failures++; $display("FAIL reset_an_n got=%h exp=F", an_n); end
    checks++; if (seg !== 7'h00) begin failures++; $display("FAIL reset_seg got=%h exp=00", seg); end
    checks++; if (dp !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b exp=0", dp); end
    checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL reset_load_ack got=%b exp=0", load_ack); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_idle_dark();
    int n;
    wait_fd(n);
    checks++; if (n != FL) begin failures++; $display("FAIL idle_first_frame_done got=%0d exp=%0d", n, FL); end
    capture();
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({cap_an[j], cap_seg[j], cap_dp[j]} !== exp_slot(dark_fr, j, 1'b0)) begin
        failures++;
        $display("FAIL idle_slot j=%0d got=%h exp=%h", j, {cap_an[j], cap_seg[j], cap_dp[j]}, exp_slot(dark_fr, j, 1'b0));
      end
      checks++;
      if (cap_fd[j] !== (j == FL - 1) || cap_ack[j] !== 1'b0) begin
        failures++;
        $display("FAIL idle_pulses j=%0d got fd=%b ack=%b", j, cap_fd[j], cap_ack[j]);
      end
    end
  endtask

  task automatic test_load_display();
    int n;
    frame_t fr;
    fr = '{dig: 16'h3210, blank: 4'h0, dpm: 4'b0100, blink: 4'h0};
    drive_load(fr);
    sb_q.push_back(fr);
    wait_fd(n);
    checks++; if (n < 0 || load_ack !== 1'b1) begin failures++; $display("FAIL load_ack got n=%0d ack=%b exp ack=1", n, load_ack); end
    if (sb_q.size() > 0) exp_fr = sb_q.pop_front();
    capture();
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({cap_an[j], cap_seg[j], cap_dp[j]} !== exp_slot(exp_fr, j, 1'b0)) begin
        failures++;
        $display("FAIL load_display_slot j=%0d got=%h exp=%h", j, {cap_an[j], cap_seg[j], cap_dp[j]}, exp_slot(exp_fr, j, 1'b0));
      end
    end
    checks++; if (cap_ack[FL-1] !== 1'b0) begin failures++; $display("FAIL load_display_no_reack got=%b exp=0", cap_ack[FL-1]); end
  endtask

  task automatic test_last_wins();
    int n;
    frame_t f1, f2;
    f1 = '{dig: 16'h1111, blank: 4'h0, dpm: 4'h0, blink: 4'h0};
    f2 = '{dig: 16'h2222, blank: 4'h0, dpm: 4'h0, blink: 4'h0};
    drive_load(f1);
    sb_q.push_back(f1);
    step(3);
    drive_load(f2);
    sb_q[sb_q.size() - 1] = f2;
    wait_fd(n);
    checks++; if (n < 0 || load_ack !== 1'b1) begin failures++; $display("FAIL last_wins_ack got n=%0d ack=%b exp ack=1", n, load_ack); end
    if (sb_q.size() > 0) exp_fr = sb_q.pop_front();
    capture();
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({cap_an[j], cap_seg[j], cap_dp[j]} !== exp_slot(exp_fr, j, 1'b0)) begin
        failures++;
        $display("FAIL last_wins_slot j=%0d got=%h exp=%h", j, {cap_an[j], cap_seg[j], cap_dp[j]}, exp_slot(exp_fr, j, 1'b0));
      end
    end
    checks++; if (cap_ack[FL-1] !== 1'b0) begin failures++; $display("FAIL last_wins_single_ack got=%b exp=0", cap_ack[FL-1]); end
  endtask

  task automatic test_blink();
    int n;
    logic ph;
    frame_t fr;
    do_reset();
    fr = '{dig: 16'h3210, blank: 4'h0, dpm: 4'h0, blink: 4'b0001};
    drive_load(fr);
    sb_q.push_back(fr);
    wait_fd(n);
    checks++; if (n != FL - 1 || load_ack !== 1'b1) begin failures++; $display("FAIL blink_ack got n=%0d ack=%b exp n=%0d ack=1", n, load_ack, FL - 1); end
    if (sb_q.size() > 0) exp_fr = sb_q.pop_front();
    for (int f = 1; f <= 5; f++) begin
      ph = ((f / BF) % 2) == 1;
      capture();
      for (int j = 0; j < FL; j++) begin
        checks++;
        if ({cap_an[j], cap_seg[j], cap_dp[j]} !== exp_slot(exp_fr, j, ph)) begin
          failures++;
          $display("FAIL blink_slot frame=%0d j=%0d got=%h exp=%h", f, j, {cap_an[j], cap_seg[j], cap_dp[j]}, exp_slot(exp_fr, j, ph));
        end
      end
    end
  endtask

  task automatic test_load_on_boundary();
    int n;
    frame_t fr;
    fr = '{dig: 16'hABCD, blank: 4'h0, dpm: 4'b1010, blink: 4'h0};
    step(FL - 1);
    drive_load(fr);
    checks++; if (frame_done !== 1'b1 || load_ack !== 1'b0) begin failures++; $display("FAIL boundary_load_no_ack got fd=%b ack=%b exp fd=1 ack=0", frame_done, load_ack); end
    sb_q.push_back(fr);
    wait_fd(n);
    checks++; if (n != FL || load_ack !== 1'b1) begin failures++; $display("FAIL boundary_load_ack got n=%0d ack=%b exp n=%0d ack=1", n, load_ack, FL); end
    if (sb_q.size() > 0) exp_fr = sb_q.pop_front();
    capture();
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({cap_an[j], cap_seg[j], cap_dp[j]} !== exp_slot(exp_fr, j, 1'b0)) begin
        failures++;
        $display("FAIL boundary_load_slot j=%0d got=%h exp=%h", j, {cap_an[j], cap_seg[j], cap_dp[j]}, exp_slot(exp_fr, j, 1'b0));
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t fx, fy;
    fx = '{dig: 16'h4567, blank: 4'h0, dpm: 4'b0001, blink: 4'h0};
    fy = '{dig: 16'h89EF, blank: 4'b0100, dpm: 4'b1000, blink: 4'h0};
    drive_load(fx);
    sb_q.push_back(fx);
    step(FL - 2);
    drive_load(fy);
    checks++; if (frame_done !== 1'b1 || load_ack !== 1'b1) begin failures++; $display("FAIL b2b_first_ack got fd=%b ack=%b exp fd=1 ack=1", frame_done, load_ack); end
    if (sb_q.size() > 0) exp_fr = sb_q.pop_front();
    sb_q.push_back(fy);
    capture();
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({cap_an[j], cap_seg[j], cap_dp[j]} !== exp_slot(exp_fr, j, 1'b0)) begin
        failures++;
        $display("FAIL b2b_first_slot j=%0d got=%h exp=%h", j, {cap_an[j], cap_seg[j], cap_dp[j]}, exp_slot(exp_fr, j, 1'b0));
      end
    end
    checks++; if (cap_ack[FL-1] !== 1'b1) begin failures++; $display("FAIL b2b_second_ack got=%b exp=1", cap_ack[FL-1]); end
    if (sb_q.size() > 0) exp_fr = sb_q.pop_front();
    capture();
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({cap_an[j], cap_seg[j], cap_dp[j]} !== exp_slot(exp_fr, j, 1'b0)) begin
        failures++;
        $display("FAIL b2b_second_slot j=%0d got=%h exp=%h", j, {cap_an[j], cap_seg[j], cap_dp[j]}, exp_slot(exp_fr, j, 1'b0));
      end
    end
    checks++; if (cap_ack[FL-1] !== 1'b0) begin failures++; $display("FAIL b2b_no_third_ack got=%b exp=0", cap_ack[FL-1]); end
  endtask

  task automatic test_enable();
    int n;
    logic [11:0] lit;
    lit = exp_slot(exp_fr, 1, 1'b0);
    step(2);
    checks++; if ({an_n, seg, dp} !== lit) begin failures++; $display("FAIL enable_before got=%h exp=%h", {an_n, seg, dp}, lit); end
    en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      checks++;
      if ({an_n, seg, dp} !== 12'hF00 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL enable_frozen k=%0d got=%h fd=%b exp=f00 fd=0", k, {an_n, seg, dp}, frame_done);
      end
    end
    en = 1'b1;
    step(1);
    checks++; if ({an_n, seg, dp} !== exp_slot(exp_fr, 2, 1'b0)) begin failures++; $display("FAIL enable_resume got=%h exp=%h", {an_n, seg, dp}, exp_slot(exp_fr, 2, 1'b0)); end
    wait_fd(n);
    checks++; if (n != FL - 3 || load_ack !== 1'b0) begin failures++; $display("FAIL enable_frame_done got n=%0d ack=%b exp n=%0d ack=0", n, load_ack, FL - 3); end
  endtask

  task automatic test_async_reset();
    int n;
    frame_t fz, fw;
    fz = '{dig: 16'h5555, blank: 4'h0, dpm: 4'h0, blink: 4'h0};
    fw = '{dig: 16'h0F0F, blank: 4'h0, dpm: 4'b0010, blink: 4'h0};
    drive_load(fz);
    step(1);
    checks++; if (an_n !== 4'b1110) begin failures++; $display("FAIL async_pre_lit got=%h exp=e", an_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({an_n, seg, dp} !== 12'hF00) begin failures++; $display("FAIL async_reset_dark got=%h exp=f00", {an_n, seg, dp}); end
    step(1);
    rst_n = 1'b1;
    wait_fd(n);
    checks++; if (n != FL || load_ack !== 1'b0) begin failures++; $display("FAIL async_pending_discarded got n=%0d ack=%b exp n=%0d ack=0", n, load_ack, FL); end
    capture();
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({cap_an[j], cap_seg[j], cap_dp[j], cap_ack[j]} !== {exp_slot(dark_fr, j, 1'b0), 1'b0}) begin
        failures++;
        $display("FAIL async_dark_slot j=%0d got=%h ack=%b exp=%h", j, {cap_an[j], cap_seg[j], cap_dp[j]}, cap_ack[j], exp_slot(dark_fr, j, 1'b0));
      end
    end
    drive_load(fw);
    sb_q.push_back(fw);
    wait_fd(n);
    checks++; if (n < 0 || load_ack !== 1'b1) begin failures++; $display("FAIL async_reload_ack got n=%0d ack=%b exp ack=1", n, load_ack); end
    if (sb_q.size() > 0) exp_fr = sb_q.pop_front();
    capture();
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({cap_an[j], cap_seg[j], cap_dp[j]} !== exp_slot(exp_fr, j, 1'b0)) begin
        failures++;
        $display("FAIL async_reload_slot j=%0d got=%h exp=%h", j, {cap_an[j], cap_seg[j], cap_dp[j]}, exp_slot(exp_fr, j, 1'b0));
      end
    end
  endtask

  initial begin
    dark_fr = '{dig: 16'h0000, blank: 4'hF, dpm: 4'h0, blink: 4'h0};
    exp_fr  = dark_fr;
    test_reset();
    test_idle_dark();
    test_load_display();
    test_last_wins();
    test_blink();
    test_load_on_boundary();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
